// File: rtl/flow_pifo.sv
// Multi-flow PIFO: per-flow circular FIFOs, and a combinational minimum-rank search
// across the flow heads (ties go to the lowest flow index) that drives the show-ahead pop port.
module flow_pifo #(
   parameter int FLOWS   = 10,
   parameter int DEPTH   = 8,
   parameter int RANK_W  = 32,
   parameter int VALUE_W = 32,
   parameter int FLOW_W  = $clog2(FLOWS),
   parameter int OCC_W   = $clog2(FLOWS*DEPTH+1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic [RANK_W-1:0]  push_rank,
   input  logic [VALUE_W-1:0] push_value,
   input  logic [FLOW_W-1:0]  push_flow,
   output logic               push_ready,
   input  logic               pop,
   output logic               pop_valid,
   output logic [VALUE_W-1:0] pop_value,
   output logic [RANK_W-1:0]  pop_rank,
   output logic [FLOW_W-1:0]  pop_flow,
   output logic [OCC_W-1:0]   occupancy,
   output logic [15:0]        drop_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH-1);
   localparam logic [FLOW_W:0]   FLOWS_EXT = (FLOW_W+1)'(FLOWS);

   logic [RANK_W-1:0]  r_rank  [FLOWS][DEPTH];
   logic [VALUE_W-1:0] r_value [FLOWS][DEPTH];
   logic [PTR_W-1:0]   r_rdPtr [FLOWS];
   logic [PTR_W-1:0]   r_wrPtr [FLOWS];
   logic [CNT_W-1:0]   r_cnt   [FLOWS];
   logic [OCC_W-1:0]   r_occ;
   logic [15:0]        r_drops;

   logic [CNT_W-1:0]   w_pushCnt;
   logic               w_pushLegal;
   logic               w_pushReady;
   logic               w_pushFire;
   logic               w_found;
   logic [FLOW_W-1:0]  w_winFlow;
   logic [RANK_W-1:0]  w_winRank;
   logic [VALUE_W-1:0] w_winValue;
   logic               w_popFire;
   logic               w_pushHit [FLOWS];
   logic               w_popHit  [FLOWS];

   // Push readiness looks only at registered counts, so a same-cycle pop never frees a slot.
   always_comb begin
      w_pushCnt = '0;
      for (int f = 0; f < FLOWS; f++) begin
         if (push_flow == FLOW_W'(f)) begin
            w_pushCnt = r_cnt[f];
         end
      end
      w_pushLegal = ({1'b0, push_flow} < FLOWS_EXT);
      w_pushReady = w_pushLegal && (w_pushCnt != CNT_FULL);
      w_pushFire  = push && w_pushReady;
   end

   // Strict less-than keeps the earliest (lowest-index) flow on equal ranks.
   always_comb begin
      w_found    = 1'b0;
      w_winFlow  = '0;
      w_winRank  = '0;
      w_winValue = '0;
      for (int f = 0; f < FLOWS; f++) begin
         if (r_cnt[f] != '0) begin
            if (!w_found || (r_rank[f][r_rdPtr[f]] < w_winRank)) begin
               w_found    = 1'b1;
               w_winFlow  = FLOW_W'(f);
               w_winRank  = r_rank[f][r_rdPtr[f]];
               w_winValue = r_value[f][r_rdPtr[f]];
            end
         end
      end
      w_popFire = pop && w_found;
   end

   always_comb begin
      for (int f = 0; f < FLOWS; f++) begin
         w_pushHit[f] = w_pushFire && (push_flow == FLOW_W'(f));
         w_popHit[f]  = w_popFire && (w_winFlow == FLOW_W'(f));
      end
   end

   // Payload storage carries no reset; validity is tracked entirely by the counts.
   always_ff @(posedge clk) begin
      for (int f = 0; f < FLOWS; f++) begin
         if (w_pushHit[f]) begin
            r_rank[f][r_wrPtr[f]]  <= push_rank;
            r_value[f][r_wrPtr[f]] <= push_value;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int f = 0; f < FLOWS; f++) begin
            r_rdPtr[f] <= '0;
            r_wrPtr[f] <= '0;
            r_cnt[f]   <= '0;
         end
      end else begin
         for (int f = 0; f < FLOWS; f++) begin
            if (w_pushHit[f]) begin
               r_wrPtr[f] <= (r_wrPtr[f] == PTR_LAST) ? '0 : r_wrPtr[f] + PTR_W'(1);
            end
            if (w_popHit[f]) begin
               r_rdPtr[f] <= (r_rdPtr[f] == PTR_LAST) ? '0 : r_rdPtr[f] + PTR_W'(1);
            end
            if (w_pushHit[f] && !w_popHit[f]) begin
               r_cnt[f] <= r_cnt[f] + CNT_W'(1);
            end else if (w_popHit[f] && !w_pushHit[f]) begin
               r_cnt[f] <= r_cnt[f] - CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_occ   <= '0;
         r_drops <= '0;
      end else begin
         if (w_pushFire && !w_popFire) begin
            r_occ <= r_occ + OCC_W'(1);
         end else if (w_popFire && !w_pushFire) begin
            r_occ <= r_occ - OCC_W'(1);
         end
         if (push && !w_pushReady && (r_drops != 16'hFFFF)) begin
            r_drops <= r_drops + 16'd1;
         end
      end
   end

   assign push_ready = w_pushReady;
   assign pop_valid  = w_found;
   assign pop_value  = w_winValue;
   assign pop_rank   = w_winRank;
   assign pop_flow   = w_winFlow;
   assign occupancy  = r_occ;
   assign drop_count = r_drops;

endmodule

// File: tb/tb_flow_pifo.sv
// Self-checking bench for flow_pifo: directed scenarios plus random traffic,
// compared every cycle against a per-flow queue model of the PIFO.
module tb_flow_pifo;

   localparam int FLOWS   = 10;
   localparam int DEPTH   = 8;
   localparam int RANK_W  = 32;
   localparam int VALUE_W = 32;
   localparam int FLOW_W  = $clog2(FLOWS);
   localparam int OCC_W   = $clog2(FLOWS*DEPTH+1);

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               push = 1'b0;
   logic [RANK_W-1:0]  push_rank = '0;
   logic [VALUE_W-1:0] push_value = '0;
   logic [FLOW_W-1:0]  push_flow = '0;
   logic               push_ready;
   logic               pop = 1'b0;
   logic               pop_valid;
   logic [VALUE_W-1:0] pop_value;
   logic [RANK_W-1:0]  pop_rank;
   logic [FLOW_W-1:0]  pop_flow;
   logic [OCC_W-1:0]   occupancy;
   logic [15:0]        drop_count;

   int checkCount = 0;
   int errorCount = 0;

   // Model: each flow is a queue of {rank, value}; drops tracked separately.
   logic [63:0] mq [FLOWS][$];
   int          mDrops = 0;

   flow_pifo #(
      .FLOWS(FLOWS), .DEPTH(DEPTH), .RANK_W(RANK_W), .VALUE_W(VALUE_W),
      .FLOW_W(FLOW_W), .OCC_W(OCC_W)
   ) dut (
      .clk(clk), .rst(rst),
      .push(push), .push_rank(push_rank), .push_value(push_value),
      .push_flow(push_flow), .push_ready(push_ready),
      .pop(pop), .pop_valid(pop_valid), .pop_value(pop_value),
      .pop_rank(pop_rank), .pop_flow(pop_flow),
      .occupancy(occupancy), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic int modelWinner();
      int w = -1;
      for (int f = 0; f < FLOWS; f++) begin
         if (mq[f].size() > 0) begin
            if (w < 0 || mq[f][0][63:32] < mq[w][0][63:32]) w = f;
         end
      end
      return w;
   endfunction

   function automatic logic modelReady(input int flow);
      if (flow >= FLOWS) return 1'b0;
      return mq[flow].size() < DEPTH;
   endfunction

   function automatic int modelOcc();
      int n = 0;
      for (int f = 0; f < FLOWS; f++) n += mq[f].size();
      return n;
   endfunction

   task automatic checkAll(input int flow);
      int w;
      w = modelWinner();
      checkOutput("push_ready", 64'(push_ready), 64'(modelReady(flow)));
      checkOutput("pop_valid", 64'(pop_valid), (w >= 0) ? 64'd1 : 64'd0);
      checkOutput("pop_rank", 64'(pop_rank), (w >= 0) ? 64'(mq[w][0][63:32]) : 64'd0);
      checkOutput("pop_value", 64'(pop_value), (w >= 0) ? 64'(mq[w][0][31:0]) : 64'd0);
      checkOutput("pop_flow", 64'(pop_flow), (w >= 0) ? 64'(w) : 64'd0);
      checkOutput("occupancy", 64'(occupancy), 64'(modelOcc()));
      checkOutput("drop_count", 64'(drop_count), 64'(mDrops));
   endtask

   task automatic applyStimulus(input logic doPush, input int flow, input logic [31:0] rank,
                                input logic [31:0] value, input logic doPop);
      int  w;
      logic rdy;
      @(negedge clk);
      push       = doPush;
      push_flow  = FLOW_W'(flow);
      push_rank  = rank;
      push_value = value;
      pop        = doPop;
      #1 checkAll(flow);
      w   = modelWinner();
      rdy = modelReady(flow);
      @(posedge clk);
      if (doPop && w >= 0) void'(mq[w].pop_front());
      if (doPush) begin
         if (rdy) mq[flow].push_back({rank, value});
         else if (mDrops < 16'hFFFF) mDrops++;
      end
   endtask

   task automatic clearModel();
      for (int f = 0; f < FLOWS; f++) mq[f].delete();
      mDrops = 0;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1; push = 1'b0; pop = 1'b0;
      clearModel();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      push_flow = '0;
      #1;
      checkOutput("resetOcc", 64'(occupancy), 64'd0);
      checkOutput("resetValid", 64'(pop_valid), 64'd0);
      checkOutput("resetReady", 64'(push_ready), 64'd1);
      checkOutput("resetDrops", 64'(drop_count), 64'd0);
      rst = 1'b0;

      // Single push then pop.
      applyStimulus(1, 2, 5, 32'hA, 0);
      #2;
      checkOutput("t1Flow", 64'(pop_flow), 64'd2);
      checkOutput("t1Value", 64'(pop_value), 64'hA);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0);

      // Rank ordering with tie to lowest flow.
      applyStimulus(1, 0, 9, 1, 0);
      applyStimulus(1, 1, 3, 2, 0);
      applyStimulus(1, 2, 3, 3, 0);
      #2 checkOutput("t2First", 64'(pop_value), 64'd2);
      applyStimulus(0, 0, 0, 0, 1);
      #2 checkOutput("t2Second", 64'(pop_value), 64'd3);
      applyStimulus(0, 0, 0, 0, 1);
      #2 checkOutput("t2Third", 64'(pop_value), 64'd1);
      applyStimulus(0, 0, 0, 0, 1);

      // FIFO order within a flow; only heads compete.
      applyStimulus(1, 4, 7, 40, 0);
      applyStimulus(1, 4, 1, 41, 0);
      applyStimulus(1, 5, 4, 50, 0);
      #2 checkOutput("t3First", 64'(pop_flow), 64'd5);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1);

      // Full flow, drops, and push+pop on a full flow.
      for (int i = 0; i < DEPTH; i++) applyStimulus(1, 3, 32'(i), 32'(100 + i), 0);
      applyStimulus(0, 3, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(1, 3, 1, 1, 0);
      applyStimulus(1, 3, 1, 1, 0);
      #2 checkOutput("t4Drops", 64'(drop_count), 64'd2);
      applyStimulus(1, 3, 1, 1, 1);
      #2 checkOutput("t4Occ", 64'(occupancy), 64'd7);
      doReset();

      // Wrap-around on flow 1.
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1, 1, 32'(i), 32'(200 + i), 0);
         applyStimulus(0, 0, 0, 0, 1);
      end
      applyStimulus(1, 1, 3, 77, 0);
      applyStimulus(1, 1, 4, 78, 1);
      applyStimulus(0, 1, 0, 0, 0);

      // Asynchronous reset mid-cycle with contents and drops.
      doReset();
      for (int i = 0; i < 5; i++) applyStimulus(1, i, 32'(i), 32'(i), 0);
      for (int i = 0; i < 3; i++) applyStimulus(1, 12, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      @(negedge clk);
      push = 1'b0; pop = 1'b0;
      #2 rst = 1'b1;
      #1;
      checkOutput("asyncOcc", 64'(occupancy), 64'd0);
      checkOutput("asyncDrops", 64'(drop_count), 64'd0);
      checkOutput("asyncValid", 64'(pop_valid), 64'd0);
      clearModel();
      @(negedge clk);
      rst = 1'b0;

      // Random traffic with small ranks for frequent ties and some illegal flows.
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom_range(0, 9) < 6), int'($urandom_range(0, 11)),
                       32'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 9) < 5));
      end
      applyStimulus(0, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
